// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: prioritised freeze vector, load-use detection, exc/ERET flush + drain FSM.
// Optional perf counters enabled by `define PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_req_if,
  input  logic                      stall_req_id,
  input  logic                      stall_req_ex,
  input  logic                      stall_req_mem,
  input  logic                      id_reg_read_en_1,
  input  logic                      id_reg_read_en_2,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_addr_1,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_addr_2,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg_addr,
  input  logic                      exc_valid,
  input  logic [ADDR_WIDTH-1:0]     exc_pc,
  input  logic                      eret_valid,
  input  logic [ADDR_WIDTH-1:0]     epc,
  output logic [4:0]                stall,
  output logic                      flush,
  output logic [ADDR_WIDTH-1:0]     flush_pc,
  output logic                      load_use
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycle_cnt,
  output logic [31:0]               load_use_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       hazard;
  logic       take_event;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign hazard = ex_is_load && (ex_write_reg_addr != '0) &&
                  ((id_reg_read_en_1 && (id_reg_addr_1 == ex_write_reg_addr)) ||
                   (id_reg_read_en_2 && (id_reg_addr_2 == ex_write_reg_addr)));

  assign take_event = (exc_valid || eret_valid) && !stall_req_mem;

  always_comb begin
    stall    = 5'b00000;
    load_use = 1'b0;
    if (rst) begin
      load_use = hazard;
      // The flush cycle clears every stage, so holding any of them would be meaningless.
      if (state != FLUSH) begin
        if (stall_req_mem)                stall = 5'b11111;
        else if (stall_req_ex)            stall = 5'b01111;
        else if (stall_req_id || hazard)  stall = 5'b00111;
        else if (stall_req_if)            stall = 5'b00011;
        else                              stall = 5'b00000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush <= 1'b0;
          if (take_event) begin
            state    <= FLUSH;
            flush    <= 1'b1;
            flush_pc <= exc_valid ? exc_pc : epc;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          flush     <= 1'b0;
          drain_cnt <= DRAIN_INIT;
        end
        DRAIN: begin
          flush <= 1'b0;
          // A MEM stall freezes the pipeline, so the drain window freezes with it.
          if (!stall_req_mem) begin
            if (drain_cnt == 4'd0) state <= IDLE;
            else                   drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycle_cnt <= '0;
      load_use_cnt    <= '0;
    end else begin
      if (stall[0] && (stall_cycle_cnt != 32'hFFFF_FFFF)) stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
      if (load_use && (load_use_cnt != 32'hFFFF_FFFF))    load_use_cnt    <= load_use_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; expectations queued by stimulus, checked by a negedge monitor.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        id_reg_read_en_1, id_reg_read_en_2;
  logic [4:0]  id_reg_addr_1, id_reg_addr_2;
  logic        ex_is_load;
  logic [4:0]  ex_write_reg_addr;
  logic        exc_valid, eret_valid;
  logic [31:0] exc_pc, epc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        load_use;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycle_cnt, load_use_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
    .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
    .id_reg_read_en_1(id_reg_read_en_1), .id_reg_read_en_2(id_reg_read_en_2),
    .id_reg_addr_1(id_reg_addr_1), .id_reg_addr_2(id_reg_addr_2),
    .ex_is_load(ex_is_load), .ex_write_reg_addr(ex_write_reg_addr),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .eret_valid(eret_valid), .epc(epc),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .load_use(load_use)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    , .stall_cycle_cnt(stall_cycle_cnt), .load_use_cnt(load_use_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    logic        chk_fpc;
    logic        lu;
    logic        chk_cnt;
    logic [31:0] scnt;
    logic [31:0] lcnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, field, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "stall", {27'd0, stall}, {27'd0, e.stall});
      chk(e.name, "flush", {31'd0, flush}, {31'd0, e.flush});
      chk(e.name, "load_use", {31'd0, load_use}, {31'd0, e.lu});
      if (e.chk_fpc) chk(e.name, "flush_pc", flush_pc, e.fpc);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      if (e.chk_cnt) begin
        chk(e.name, "stall_cycle_cnt", stall_cycle_cnt, e.scnt);
        chk(e.name, "load_use_cnt", load_use_cnt, e.lcnt);
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [4:0] s, input logic f, input logic [31:0] pc,
                            input logic chk_pc, input logic lu, input string nm);
    exp_t e;
    e.stall = s; e.flush = f; e.fpc = pc; e.chk_fpc = chk_pc; e.lu = lu;
    e.chk_cnt = 1'b0; e.scnt = '0; e.lcnt = '0; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_cnt(input logic [4:0] s, input logic lu, input logic [31:0] sc,
                            input logic [31:0] lc, input string nm);
    exp_t e;
    e.stall = s; e.flush = 1'b0; e.fpc = '0; e.chk_fpc = 1'b0; e.lu = lu;
    e.chk_cnt = 1'b1; e.scnt = sc; e.lcnt = lc; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    rst = 1'b1;
    stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    id_reg_read_en_1 = 0; id_reg_read_en_2 = 0; id_reg_addr_1 = 0; id_reg_addr_2 = 0;
    ex_is_load = 0; ex_write_reg_addr = 0;
    exc_valid = 0; eret_valid = 0; exc_pc = 0; epc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b0;
    stall_req_if = 1; stall_req_id = 1; stall_req_ex = 1; stall_req_mem = 1;
    exc_valid = 1; eret_valid = 1; exc_pc = 32'hDEAD0000; epc = 32'hBEEF0000;
    ex_is_load = 1; ex_write_reg_addr = 5'd4; id_reg_read_en_1 = 1; id_reg_addr_1 = 5'd4;

    cyc(); expect_out(5'b00000, 0, 32'h0, 1, 0, "reset0");
    cyc(); expect_out(5'b00000, 0, 32'h0, 1, 0, "reset1");
    cyc(); clr(); stall_req_if = 1; stall_req_id = 1; stall_req_ex = 1; stall_req_mem = 1;
    expect_out(5'b11111, 0, 32'h0, 1, 0, "release");

    cyc(); clr(); expect_out(5'b00000, 0, 32'h0, 1, 0, "idle");

    // load-use detection
    cyc(); clr(); ex_is_load = 1; ex_write_reg_addr = 5'd8; id_reg_read_en_2 = 1; id_reg_addr_2 = 5'd8;
    expect_out(5'b00111, 0, 32'h0, 0, 1, "lu_port2");
    cyc(); ex_write_reg_addr = 5'd0; id_reg_addr_2 = 5'd0;
    expect_out(5'b00000, 0, 32'h0, 0, 0, "lu_r0");
    cyc(); clr(); ex_is_load = 1; ex_write_reg_addr = 5'd3; id_reg_read_en_1 = 1; id_reg_addr_1 = 5'd3;
    expect_out(5'b00111, 0, 32'h0, 0, 1, "lu_port1");
    cyc(); id_reg_read_en_1 = 0;
    expect_out(5'b00000, 0, 32'h0, 0, 0, "lu_no_en");
    cyc(); id_reg_read_en_1 = 1; ex_is_load = 0;
    expect_out(5'b00000, 0, 32'h0, 0, 0, "lu_not_load");

    // priority
    cyc(); clr(); stall_req_if = 1; stall_req_ex = 1;
    expect_out(5'b01111, 0, 32'h0, 0, 0, "prio_if_ex");
    cyc(); stall_req_mem = 1;
    expect_out(5'b11111, 0, 32'h0, 0, 0, "prio_mem");
    cyc(); clr(); stall_req_if = 1;
    expect_out(5'b00011, 0, 32'h0, 0, 0, "prio_if");
    cyc(); stall_req_id = 1;
    expect_out(5'b00111, 0, 32'h0, 0, 0, "prio_id");

    // exception wins over ERET; flush suppresses stall; drain ignores events
    cyc(); clr(); exc_valid = 1; exc_pc = 32'hBFC00380; eret_valid = 1; epc = 32'h80001000; stall_req_ex = 1;
    expect_out(5'b01111, 0, 32'h0, 0, 0, "exc_issue");
    cyc(); clr(); stall_req_ex = 1;
    expect_out(5'b00000, 1, 32'hBFC00380, 1, 0, "exc_flush");
    cyc(); clr(); exc_valid = 1; exc_pc = 32'h12345678;
    expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "drain1");
    cyc(); expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "drain2");
    cyc(); clr(); expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "post_drain0");
    cyc(); expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "post_drain1");

    // ERET alone
    cyc(); clr(); eret_valid = 1; epc = 32'h80001000;
    expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "eret_issue");
    cyc(); clr(); expect_out(5'b00000, 1, 32'h80001000, 1, 0, "eret_flush");
    cyc(); expect_out(5'b00000, 0, 32'h80001000, 1, 0, "eret_drain1");
    cyc(); expect_out(5'b00000, 0, 32'h80001000, 1, 0, "eret_drain2");

    // event blocked by MEM stall, then drain frozen by MEM stall
    for (int i = 0; i < 3; i++) begin
      cyc(); clr(); exc_valid = 1; exc_pc = 32'hBFC00380; stall_req_mem = 1;
      expect_out(5'b11111, 0, 32'h80001000, 1, 0, "blocked");
    end
    cyc(); stall_req_mem = 0;
    expect_out(5'b00000, 0, 32'h80001000, 1, 0, "blk_release");
    cyc(); clr(); expect_out(5'b00000, 1, 32'hBFC00380, 1, 0, "blk_flush");
    cyc(); stall_req_mem = 1; expect_out(5'b11111, 0, 32'h0, 0, 0, "drain_mem1");
    cyc(); expect_out(5'b11111, 0, 32'h0, 0, 0, "drain_mem2");
    cyc(); clr(); expect_out(5'b00000, 0, 32'h0, 0, 0, "drain_cnt1");
    cyc(); exc_valid = 1; exc_pc = 32'h0000AAAA;
    expect_out(5'b00000, 0, 32'h0, 0, 0, "drain_cnt0");
    cyc(); clr(); expect_out(5'b00000, 0, 32'hBFC00380, 1, 0, "drain_frozen");

    // reset in the middle of FLUSH
    cyc(); exc_valid = 1; exc_pc = 32'h00002000;
    expect_out(5'b00000, 0, 32'h0, 0, 0, "rst_issue");
    cyc(); clr(); rst = 0; stall_req_ex = 1;
    expect_out(5'b00000, 1, 32'h00002000, 1, 0, "rst_in_flush");
    cyc(); clr(); exc_valid = 1; exc_pc = 32'h00001000;
    expect_out(5'b00000, 0, 32'h0, 1, 0, "rst_cleared");
    cyc(); clr(); expect_out(5'b00000, 1, 32'h00001000, 1, 0, "rst_then_idle");
    cyc(); expect_out(5'b00000, 0, 32'h0, 0, 0, "rst_drain1");
    cyc(); expect_out(5'b00000, 0, 32'h0, 0, 0, "rst_drain2");

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    cyc(); clr(); rst = 0; expect_out(5'b00000, 0, 32'h0, 0, 0, "perf_rst");
    cyc(); clr(); stall_req_ex = 1; expect_cnt(5'b01111, 0, 32'd0, 32'd0, "perf_start");
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_out(5'b01111, 0, 32'h0, 0, 0, "perf_ex");
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); clr(); ex_is_load = 1; ex_write_reg_addr = 5'd9; id_reg_read_en_1 = 1; id_reg_addr_1 = 5'd9;
      expect_out(5'b00111, 0, 32'h0, 0, 1, "perf_lu");
    end
    cyc(); clr(); expect_cnt(5'b00000, 0, 32'd6, 32'd2, "perf_end");
`endif

    cyc();
    cyc();
    chk("scoreboard", "pending", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges per-stage stall requests with an internally detected load-use hazard against the decode stage's register reads.
- Emits a per-stage freeze vector.
- Runs a small FSM that turns a MEM-stage exception or ERET into a registered one-cycle pipeline flush with redirect PC, followed by a configurable drain window.

Parameters:
- ADDR_WIDTH, 32, width of PC / redirect address.
- REG_ADDR_WIDTH, 5, GPR address width.
- DRAIN_CYCLES, 2, cycles after a flush during which new exc/eret events are ignored (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- stall_req_if  in  1  fetch stage not ready
- stall_req_id  in  1  decode stage requests hold
- stall_req_ex  in  1  execute busy (mult/div)
- stall_req_mem  in  1  data memory not ready
- id_reg_read_en_1  in  1  decode reads port 1
- id_reg_read_en_2  in  1  decode reads port 2
- id_reg_addr_1  in  REG_ADDR_WIDTH  decode read address 1
- id_reg_addr_2  in  REG_ADDR_WIDTH  decode read address 2
- ex_is_load  in  1  instruction in EX is a load
- ex_write_reg_addr  in  REG_ADDR_WIDTH  EX destination register
- exc_valid  in  1  exception committed in MEM
- exc_pc  in  ADDR_WIDTH  exception handler address
- eret_valid  in  1  ERET committed in MEM
- epc  in  ADDR_WIDTH  return address for ERET
- stall  out  5  freeze vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
- flush  out  1  clear all pipeline registers (registered)
- flush_pc  out  ADDR_WIDTH  redirect target, valid while flush=1
- load_use  out  1  hazard indication (debug)

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, drain counter=0, flush=0, flush_pc=0. stall and load_use are forced to 0 combinationally whenever rst=0.
- load_use = ex_is_load & (ex_write_reg_addr != 0) & ((id_reg_read_en_1 & id_reg_addr_1 == ex_write_reg_addr) | (id_reg_read_en_2 & id_reg_addr_2 == ex_write_reg_addr)). Combinational.
- Stall priority, combinational, deepest stage wins:
  - stall_req_mem -> 5'b11111
  - else stall_req_ex -> 5'b01111
  - else stall_req_id | load_use -> 5'b00111
  - else stall_req_if -> 5'b00011
  - else 5'b00000
- FSM states: IDLE, FLUSH, DRAIN.
  - IDLE: event = (exc_valid | eret_valid) & ~stall_req_mem. On event, go to FLUSH and register flush_pc = exc_valid ? exc_pc : epc (exc wins if both are asserted).
  - FLUSH: flush=1 for exactly one cycle. stall is forced to 0 in this cycle regardless of requests. Next state is DRAIN with counter=DRAIN_CYCLES-1.
  - DRAIN: flush=0. exc_valid/eret_valid are ignored. Stalls resolve normally. Counter decrements each cycle not stalled by stall_req_mem; at 0 return to IDLE. DRAIN_CYCLES=1 returns after one cycle.
- Events arriving while stall_req_mem=1 are not taken. The source must hold them until MEM is released.
- Latency: event sampled at edge N, flush=1 during cycle N+1, flush=0 at N+2.
- Reset mid-FLUSH or mid-DRAIN returns to IDLE, flush=0 at the next edge.
- flush_pc holds its last value outside FLUSH.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_CNT_EN.
- When defined, add two outputs:
  - stall_cycle_cnt [31:0]: +1 each cycle stall[0]=1.
  - load_use_cnt [31:0]: +1 each cycle load_use=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with all requests=1 -> stall=0, flush=0, flush_pc=0. Release -> stall=5'b11111.
- Load-use: ex_is_load=1, ex_write_reg_addr=5'd8, id_reg_read_en_2=1, id_reg_addr_2=5'd8 -> load_use=1, stall=5'b00111. Same with ex_write_reg_addr=0 -> stall=0.
- Priority: stall_req_if=stall_req_ex=1 -> 5'b01111. Add stall_req_mem -> 5'b11111.
- Exception: exc_valid=1, exc_pc=32'hBFC00380, eret_valid=1, epc=32'h80001000 for one cycle -> next cycle flush=1, flush_pc=32'hBFC00380, stall=0 even with stall_req_ex=1. exc_valid during the following 2 cycles -> ignored.
- Blocked event: exc_valid=1 with stall_req_mem=1 for 3 cycles, then stall_req_mem=0 -> flush rises exactly one cycle after release.
- Perf (macro on): 4 cycles stall_req_ex, then 2 cycles load-use -> stall_cycle_cnt=6, load_use_cnt=2.
